// File: rtl/ram_syn_pkg.sv
// Shared types and constants for the parametrised synchronous RAM family.
// LAT_LECTURA follows RAM_SYN_REG_SALIDA_EN so benches track the configured read latency.
package ram_syn_pkg;

  typedef enum logic {
    LIMPIA = 1'b0,
    LISTO  = 1'b1
  } estado_t;

  localparam int ANCHO_DATO_DEF = 8;
  localparam int ANCHO_DIR_DEF  = 8;

`ifdef RAM_SYN_REG_SALIDA_EN
  localparam int LAT_LECTURA = 2;
`else
  localparam int LAT_LECTURA = 1;
`endif

endpackage

// File: rtl/ram_syn_limpia.sv
// Post-reset clear sequencer: walks ptr over every address, one per cycle.
// It strobes a write at each address, then parks in LISTO with ocupado low until the next reset.
module ram_syn_limpia
  import ram_syn_pkg::*;
#(
  parameter int ANCHO_DIR = ANCHO_DIR_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [ANCHO_DIR-1:0] ptr,
  output logic                 wr_limpia,
  output logic                 ocupado
);

  localparam logic [ANCHO_DIR-1:0] ULTIMA = '1;

  estado_t estado;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado    <= LIMPIA;
      ptr       <= '0;
      wr_limpia <= 1'b1;
      ocupado   <= 1'b1;
    end else begin
      case (estado)
        LIMPIA: begin
          // The last address is written on this edge, so busy drops together with it.
          if (ptr == ULTIMA) begin
            estado    <= LISTO;
            wr_limpia <= 1'b0;
            ocupado   <= 1'b0;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        LISTO:   estado <= LISTO;
        default: estado <= LIMPIA;
      endcase
    end
  end

endmodule

// File: rtl/ram_syn_param.sv
// Simple dual-port synchronous RAM with a post-reset clear sweep; read-first on same-address collision.
// Read latency is 1 cycle, or 2 with RAM_SYN_REG_SALIDA_EN; there is no backpressure, but ports are ignored while ocupado.
module ram_syn_param
  import ram_syn_pkg::*;
#(
  parameter int                    ANCHO_DATO = ANCHO_DATO_DEF,
  parameter int                    ANCHO_DIR  = ANCHO_DIR_DEF,
  parameter logic [ANCHO_DATO-1:0] VALOR_INIT = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  EN,
  input  logic [ANCHO_DIR-1:0]  dir_e,
  input  logic [ANCHO_DATO-1:0] Dato_E,
  input  logic                  rd_en,
  input  logic [ANCHO_DIR-1:0]  dir_l,
  output logic [ANCHO_DATO-1:0] dato_s,
  output logic                  dato_valido,
  output logic                  ocupado
);

  localparam int PROF = 2 ** ANCHO_DIR;

  logic [ANCHO_DATO-1:0] mem [PROF];
  logic [ANCHO_DIR-1:0]  ptr;
  logic                  wr_limpia;
  logic                  rd_ok;

  ram_syn_limpia #(
    .ANCHO_DIR (ANCHO_DIR)
  ) u_limpia (
    .clk       (clk),
    .rst_n     (rst_n),
    .ptr       (ptr),
    .wr_limpia (wr_limpia),
    .ocupado   (ocupado)
  );

  assign rd_ok = rd_en && !ocupado;

  // Array has no reset; the sweep gives it deterministic contents instead.
  always_ff @(posedge clk) begin
    if (wr_limpia) begin
      mem[ptr] <= VALOR_INIT;
    end else if (EN && !ocupado) begin
      mem[dir_e] <= Dato_E;
    end
  end

`ifdef RAM_SYN_REG_SALIDA_EN
  logic [ANCHO_DATO-1:0] dato_1;
  logic                  vld_1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dato_1      <= '0;
      vld_1       <= 1'b0;
      dato_s      <= '0;
      dato_valido <= 1'b0;
    end else begin
      vld_1       <= rd_ok;
      dato_valido <= vld_1;
      if (rd_ok) begin
        dato_1 <= mem[dir_l];
      end
      if (vld_1) begin
        dato_s <= dato_1;
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dato_s      <= '0;
      dato_valido <= 1'b0;
    end else begin
      dato_valido <= rd_ok;
      if (rd_ok) begin
        dato_s <= mem[dir_l];
      end
    end
  end
`endif

endmodule

// File: doc/ram_syn_param.md
Name: ram_syn_param

Overview:
Parametrised successor to the 8x256 synchronous RAM. It is a simple dual-port synchronous RAM with an independent write port and read port.
- Read requests use a request/valid handshake.
- After every reset a hardware clear sequencer sweeps the array to a known value and holds ocupado high until the sweep completes.
- It sits between the datapath and register/scratch storage wherever deterministic post-reset contents are needed.

Parameters:
- ANCHO_DATO, 8, data word width in bits (1..64).
- ANCHO_DIR, 8, address width in bits; depth PROF = 2**ANCHO_DIR (2..12).
- VALOR_INIT, 0, word value written to every location by the clear sequencer (ANCHO_DATO bits).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- EN  input  1  write enable; write occurs on the clk edge when EN=1 and ocupado=0.
- dir_e  input  ANCHO_DIR  write address.
- Dato_E  input  ANCHO_DATO  write data.
- rd_en  input  1  read request; accepted when rd_en=1 and ocupado=0.
- dir_l  input  ANCHO_DIR  read address.
- dato_s  output  ANCHO_DATO  read data; holds its last value between reads.
- dato_valido  output  1  one-cycle pulse marking dato_s as the result of an accepted read.
- ocupado  output  1  high while the clear sweep is running; the ports are ignored.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - FSM goes to LIMPIA and the sweep pointer goes to 0.
  - ocupado=1, dato_s=0, dato_valido=0, all pipeline valid bits=0.
  - Array contents are not reset asynchronously.
- FSM states: LIMPIA and LISTO.
  - LIMPIA: each clk after rst_n release writes VALOR_INIT to mem[ptr] and increments ptr.
  - When ptr==PROF-1 is written, the next state is LISTO. ocupado falls on that same edge.
  - The sweep takes exactly PROF cycles from the first edge with rst_n=1.
- LIMPIA: EN and rd_en are ignored. No write happens, no dato_valido, no queuing.
- LISTO: no exit except reset.
- Write: mem[dir_e] <= Dato_E on the edge where EN=1 in LISTO. Zero-cycle latency to storage.
- Read (base configuration):
  - rd_en=1 sampled at edge N puts mem[dir_l] on dato_s, with dato_valido=1, after edge N.
  - Latency is 1 cycle.
  - Back-to-back reads every cycle are supported, with full throughput.
- Read-write collision (same edge, dir_l==dir_e): the read is read-first and returns the old contents. The new value is visible to a read on the following edge.
- dato_valido is high for exactly one cycle per accepted read. dato_s is unchanged when no read is accepted.
- Reset mid-operation:
  - Any in-flight read is dropped (dato_valido never pulses for it).
  - The sweep restarts from address 0 and discards any partial sweep.
  - Writes accepted before reset are lost after the new sweep.
- Address wrap: ptr is ANCHO_DIR bits wide; the terminal comparison is against PROF-1, with no overflow path.

Optional Feature:
Macro RAM_SYN_REG_SALIDA_EN.
- Defined: an extra output register stage is added after the array read.
  - Read latency is 2 cycles.
  - dato_valido is delayed identically.
  - Throughput stays 1 read/cycle.
  - The collision rule is unchanged: the read samples old data at request edge N.
  - The reset drop rule covers both pipeline stages.
- Undefined: 1-cycle latency as described above.

Decomposition:
- Shared package ram_syn_pkg holds:
  - the FSM state encoding (LIMPIA=1'b0, LISTO=1'b1);
  - default width constants ANCHO_DATO_DEF=8 and ANCHO_DIR_DEF=8;
  - the latency constant LAT_LECTURA (1 or 2, selected by the macro) for benches.
- One sub-module, ram_syn_limpia: the clear sequencer, which outputs ptr, a write strobe and ocupado.
- The array, ports and read pipeline stay in the top.

Test Plan (defaults 8/8, VALOR_INIT=0):
1. Release rst_n → ocupado=1 for exactly 256 clk edges, then 0. A read of address 3 then returns 0 with dato_valido 1 cycle later (2 cycles with the macro).
2. EN=1, dir_e=0, Dato_E=255; next cycle rd_en=1, dir_l=0 → dato_s=255, dato_valido a single pulse. Write 123 to address 5, read 5 → 123; address 0 still reads 255.
3. Same edge: EN=1, dir_e=9, Dato_E=77 and rd_en=1, dir_l=9 (old value 0) → dato_s=0. A read of 9 on the next edge returns 77.
4. During the sweep (cycle 10 after release): EN=1, dir_e=4, Dato_E=200 and rd_en=1 → no dato_valido. After ocupado falls, address 4 reads 0.
5. Issue a read, then assert rst_n=0 before dato_valido → dato_s=0 and dato_valido=0 immediately. The sweep restarts, with ocupado high for a full 256 cycles after release; the prior 255 at address 0 now reads 0.
6. Reads every cycle of addresses 0..7 after writing value=address+10 → dato_s sequence 10..17, dato_valido continuously high for 8 cycles.
